// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcodes and funct7 values,
// plus the operand-select and issue-register types used by the issue stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IN1_RS1,
        IN1_PC,
        IN1_ZERO
    } in1_sel_e;

    typedef enum logic {
        IN2_RS2,
        IN2_IMM
    } in2_sel_e;

    typedef struct packed {
        logic [3:0]  alu_control;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] store_data;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        branch_on_zero;
        logic        illegal;
    } issue_payload_t;

    // Shared funct3 mapping for OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] arith_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decoder: ALU operation, immediate, operand selects
// and control flags for one instruction word.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_control,
    output logic [31:0] imm,
    output in1_sel_e    in1_sel,
    output in2_sel_e    in2_sel,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        branch_on_zero,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] u_imm;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign u_imm  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    always_comb begin
        alu_control    = ALU_ADD;
        imm            = '0;
        in1_sel        = IN1_RS1;
        in2_sel        = IN2_RS2;
        reg_write      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        branch         = 1'b0;
        branch_on_zero = 1'b0;
        illegal        = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    alu_control = arith_op(funct3, funct7[5]);
                    reg_write   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                in2_sel   = IN2_IMM;
                imm       = i_imm;
                reg_write = 1'b1;
                // Shift immediates reuse the funct7 field, so it must be checked.
                if (funct3 == 3'b001) begin
                    alu_control = ALU_SLL;
                    imm         = shamt;
                    illegal     = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    alu_control = arith_op(funct3, instr[30]);
                    imm         = shamt;
                    illegal     = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end else begin
                    alu_control = arith_op(funct3, 1'b0);
                end
            end
            OPC_LOAD: begin
                in2_sel   = IN2_IMM;
                imm       = i_imm;
                mem_read  = 1'b1;
                reg_write = 1'b1;
            end
            OPC_STORE: begin
                in2_sel   = IN2_IMM;
                imm       = s_imm;
                mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                branch = 1'b1;
                case (funct3)
                    3'b000:  begin alu_control = ALU_SUB;  branch_on_zero = 1'b1; end
                    3'b001:  begin alu_control = ALU_SUB;  branch_on_zero = 1'b0; end
                    3'b100:  begin alu_control = ALU_SLT;  branch_on_zero = 1'b0; end
                    3'b101:  begin alu_control = ALU_SLT;  branch_on_zero = 1'b1; end
                    3'b110:  begin alu_control = ALU_SLTU; branch_on_zero = 1'b0; end
                    3'b111:  begin alu_control = ALU_SLTU; branch_on_zero = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                in1_sel   = IN1_ZERO;
                in2_sel   = IN2_IMM;
                imm       = u_imm;
                reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                in1_sel   = IN1_PC;
                in2_sel   = IN2_IMM;
                imm       = u_imm;
                reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal words still issue, but must not have side effects downstream.
        if (illegal) begin
            alu_control    = ALU_ILL;
            reg_write      = 1'b0;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            branch         = 1'b0;
            branch_on_zero = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes an RV32I word, selects ALU operands and holds
// the result in a single-entry valid/ready pipeline register.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_alu_control,
    output logic [DATA_W-1:0] out_in1,
    output logic [DATA_W-1:0] out_in2,
    output logic [DATA_W-1:0] out_store_data,
    output logic [DATA_W-1:0] out_pc,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_branch,
    output logic              out_branch_on_zero,
    output logic              out_illegal
);

    logic [3:0]     dec_alu_control;
    logic [31:0]    dec_imm;
    in1_sel_e       dec_in1_sel;
    in2_sel_e       dec_in2_sel;
    logic           dec_reg_write;
    logic           dec_mem_read;
    logic           dec_mem_write;
    logic           dec_branch;
    logic           dec_branch_on_zero;
    logic           dec_illegal;

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              accept;
    issue_payload_t    decoded;

    logic           valid_d, valid_q;
    issue_payload_t payload_d, payload_q;

    alu_ctrl_decode u_decode (
        .instr          (in_instr),
        .alu_control    (dec_alu_control),
        .imm            (dec_imm),
        .in1_sel        (dec_in1_sel),
        .in2_sel        (dec_in2_sel),
        .reg_write      (dec_reg_write),
        .mem_read       (dec_mem_read),
        .mem_write      (dec_mem_write),
        .branch         (dec_branch),
        .branch_on_zero (dec_branch_on_zero),
        .illegal        (dec_illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (dec_in1_sel)
            IN1_PC:   op1 = in_pc;
            IN1_ZERO: op1 = '0;
            default:  op1 = in_rs1_data;
        endcase
        op2 = (dec_in2_sel == IN2_IMM) ? dec_imm : in_rs2_data;

        decoded.alu_control    = dec_alu_control;
        decoded.in1            = op1;
        decoded.in2            = op2;
        decoded.store_data     = in_rs2_data;
        decoded.pc             = in_pc;
        decoded.rd             = dec_reg_write ? in_instr[11:7] : 5'd0;
        decoded.reg_write      = dec_reg_write;
        decoded.mem_read       = dec_mem_read;
        decoded.mem_write      = dec_mem_write;
        decoded.branch         = dec_branch;
        decoded.branch_on_zero = dec_branch_on_zero;
        decoded.illegal        = dec_illegal;
    end

    // Flush beats accept and hold; payload only moves on a surviving accept.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            payload_d = decoded;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid          = valid_q;
    assign out_alu_control    = payload_q.alu_control;
    assign out_in1            = payload_q.in1;
    assign out_in2            = payload_q.in2;
    assign out_store_data     = payload_q.store_data;
    assign out_pc             = payload_q.pc;
    assign out_rd             = payload_q.rd;
    assign out_reg_write      = payload_q.reg_write;
    assign out_mem_read       = payload_q.mem_read;
    assign out_mem_write      = payload_q.mem_write;
    assign out_branch         = payload_q.branch;
    assign out_branch_on_zero = payload_q.branch_on_zero;
    assign out_illegal        = payload_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instruction vectors with
// hand-computed decode results, plus stall, flush and reset scenarios.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_control;
    logic [31:0] out_in1;
    logic [31:0] out_in2;
    logic [31:0] out_store_data;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic        out_branch_on_zero;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_instr           (in_instr),
        .in_pc              (in_pc),
        .in_rs1_data        (in_rs1_data),
        .in_rs2_data        (in_rs2_data),
        .flush              (flush),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_alu_control    (out_alu_control),
        .out_in1            (out_in1),
        .out_in2            (out_in2),
        .out_store_data     (out_store_data),
        .out_pc             (out_pc),
        .out_rd             (out_rd),
        .out_reg_write      (out_reg_write),
        .out_mem_read       (out_mem_read),
        .out_mem_write      (out_mem_write),
        .out_branch         (out_branch),
        .out_branch_on_zero (out_branch_on_zero),
        .out_illegal        (out_illegal)
    );

    // fl = {reg_write, mem_read, mem_write, branch, branch_on_zero, illegal}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  alu;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic [5:0]  fl;
        logic        chk_ops;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[$];
    vec_t mon_e;
    vec_t v_a, v_b, v_c, v_d, v_e;
    int   n_compared = 0;
    int   n_failed   = 0;

    function automatic vec_t mkv(input string name, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] alu,
                                 input logic [31:0] in1, input logic [31:0] in2, input logic [4:0] rd,
                                 input logic [5:0] fl, input logic chk_ops);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.alu = alu; v.in1 = in1; v.in2 = in2; v.rd = rd; v.fl = fl; v.chk_ops = chk_ops;
        return v;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        n_compared++;
        if (act !== want) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, ".alu_control"}, {28'b0, out_alu_control}, 32'd0);
        checkOutput({tag, ".in1"}, out_in1, 32'd0);
        checkOutput({tag, ".in2"}, out_in2, 32'd0);
        checkOutput({tag, ".store_data"}, out_store_data, 32'd0);
        checkOutput({tag, ".pc"}, out_pc, 32'd0);
        checkOutput({tag, ".rd"}, {27'b0, out_rd}, 32'd0);
        checkOutput({tag, ".flags"}, {26'b0, out_reg_write, out_mem_read, out_mem_write,
                                      out_branch, out_branch_on_zero, out_illegal}, 32'd0);
    endtask

    // Drives one instruction (called at posedge+1) and waits, bounded, for it to be accepted.
    task automatic applyStimulus(input vec_t v, input int max_wait);
        bit accepted = 0;
        in_instr    = v.instr;
        in_pc       = v.pc;
        in_rs1_data = v.rs1;
        in_rs2_data = v.rs2;
        in_valid    = 1'b1;
        for (int w = 0; w < max_wait && !accepted; w++) begin
            @(negedge clk);
            if (flush) exp_q.delete();
            if (in_ready) begin
                if (!flush) exp_q.push_back(v);
                accepted = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput({v.name, ".accepted"}, {31'b0, accepted}, 32'd1);
    endtask

    // Monitor: each dequeue handshake is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_failed++;
                $display("[TB] FAIL unexpected_issue: got alu 0x%0h, expected no instruction", out_alu_control);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput({mon_e.name, ".alu_control"}, {28'b0, out_alu_control}, {28'b0, mon_e.alu});
                checkOutput({mon_e.name, ".pc"}, out_pc, mon_e.pc);
                checkOutput({mon_e.name, ".store_data"}, out_store_data, mon_e.rs2);
                checkOutput({mon_e.name, ".rd"}, {27'b0, out_rd}, {27'b0, mon_e.rd});
                checkOutput({mon_e.name, ".flags"}, {26'b0, out_reg_write, out_mem_read, out_mem_write,
                            out_branch, out_branch_on_zero, out_illegal}, {26'b0, mon_e.fl});
                if (mon_e.chk_ops) begin
                    checkOutput({mon_e.name, ".in1"}, out_in1, mon_e.in1);
                    checkOutput({mon_e.name, ".in2"}, out_in2, mon_e.in2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs.push_back(mkv("sub", enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h40,
                           32'd10, 32'd3, 4'b0100, 32'd10, 32'd3, 5'd3, 6'b100000, 1));
        vecs.push_back(mkv("srai", enc_i(12'h404, 5'd6, 3'b101, 5'd5, 7'b0010011), 32'h44,
                           32'hF000_0000, 32'h55, 4'b1010, 32'hF000_0000, 32'd4, 5'd5, 6'b100000, 1));
        vecs.push_back(mkv("srai_bad", enc_i(12'h024, 5'd6, 3'b101, 5'd5, 7'b0010011), 32'h48,
                           32'hF000_0000, 32'h55, 4'b1111, 32'd0, 32'd0, 5'd0, 6'b000001, 0));
        vecs.push_back(mkv("bge", {7'b0, 5'd2, 5'd1, 3'b101, 5'b01000, 7'b1100011}, 32'h4C,
                           32'd5, 32'd7, 4'b1000, 32'd5, 32'd7, 5'd0, 6'b000110, 1));
        vecs.push_back(mkv("bltu", {7'b0, 5'd2, 5'd1, 3'b110, 5'b01000, 7'b1100011}, 32'h50,
                           32'd1, 32'hFFFF_FFFF, 4'b1001, 32'd1, 32'hFFFF_FFFF, 5'd0, 6'b000100, 1));
        vecs.push_back(mkv("lui", 32'h1234_53B7, 32'h54,
                           32'h0000_DEAD, 32'h11, 4'b0010, 32'd0, 32'h1234_5000, 5'd7, 6'b100000, 1));
        vecs.push_back(mkv("auipc", 32'h0000_1417, 32'h100,
                           32'h0000_BEEF, 32'h22, 4'b0010, 32'h100, 32'h1000, 5'd8, 6'b100000, 1));
        vecs.push_back(mkv("lw", enc_i(12'hFFC, 5'd2, 3'b010, 5'd9, 7'b0000011), 32'h104,
                           32'h1000, 32'h33, 4'b0010, 32'h1000, 32'hFFFF_FFFC, 5'd9, 6'b110000, 1));
        vecs.push_back(mkv("sw", enc_s(12'hFF8, 5'd4, 5'd3, 3'b010, 7'b0100011), 32'h108,
                           32'h2000, 32'hCAFE, 4'b0010, 32'h2000, 32'hFFFF_FFF8, 5'd0, 6'b001000, 1));
        vecs.push_back(mkv("xori", enc_i(12'hFFF, 5'd2, 3'b100, 5'd1, 7'b0010011), 32'h10C,
                           32'h0F0F, 32'h44, 4'b0111, 32'h0F0F, 32'hFFFF_FFFF, 5'd1, 6'b100000, 1));
        vecs.push_back(mkv("sltu", enc_r(7'b0, 5'd5, 5'd4, 3'b011, 5'd12, 7'b0110011), 32'h110,
                           32'd2, 32'd9, 4'b1001, 32'd2, 32'd9, 5'd12, 6'b100000, 1));
        vecs.push_back(mkv("and_bad", enc_r(7'b0100000, 5'd5, 5'd4, 3'b111, 5'd10, 7'b0110011), 32'h114,
                           32'd1, 32'd2, 4'b1111, 32'd0, 32'd0, 5'd0, 6'b000001, 0));
        vecs.push_back(mkv("bad_opcode", 32'h0000_057F, 32'h118,
                           32'd1, 32'd2, 4'b1111, 32'd0, 32'd0, 5'd0, 6'b000001, 0));
        vecs.push_back(mkv("beq_f3_010", {7'b0, 5'd2, 5'd1, 3'b010, 5'b00100, 7'b1100011}, 32'h11C,
                           32'd1, 32'd2, 4'b1111, 32'd0, 32'd0, 5'd0, 6'b000001, 0));
        vecs.push_back(mkv("srl", enc_r(7'b0, 5'd5, 5'd4, 3'b101, 5'd13, 7'b0110011), 32'h120,
                           32'h80, 32'd3, 4'b0101, 32'h80, 32'd3, 5'd13, 6'b100000, 1));

        v_a = vecs[0];
        v_b = vecs[5];
        v_c = vecs[9];
        v_d = vecs[7];
        v_e = mkv("sll", enc_r(7'b0, 5'd5, 5'd4, 3'b001, 5'd10, 7'b0110011), 32'h200,
                  32'd1, 32'd4, 4'b0011, 32'd1, 32'd4, 5'd10, 6'b100000, 1);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkReset("por");
        checkOutput("por.in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) applyStimulus(vecs[i], 4);
        repeat (2) begin @(posedge clk); #1; end

        // Backpressure: hold A, offer B while stalled, then release for one cycle.
        out_ready = 1'b0;
        applyStimulus(v_a, 4);
        fork
            applyStimulus(v_b, 10);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("stall.in_ready", {31'b0, in_ready}, 32'd0);
                    checkOutput("stall.out_valid", {31'b0, out_valid}, 32'd1);
                    checkOutput("stall.alu_control", {28'b0, out_alu_control}, {28'b0, v_a.alu});
                    checkOutput("stall.in1", out_in1, v_a.in1);
                    checkOutput("stall.in2", out_in2, v_a.in2);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                @(posedge clk); #1 out_ready = 1'b0;
                @(negedge clk);
                checkOutput("nobubble.out_valid", {31'b0, out_valid}, 32'd1);
                checkOutput("nobubble.alu_control", {28'b0, out_alu_control}, {28'b0, v_b.alu});
                checkOutput("nobubble.in2", out_in2, v_b.in2);
            end
        join
        @(posedge clk);
        #1;

        // Flush while B is stalled, coinciding with an accept of C.
        flush = 1'b1;
        out_ready = 1'b1;
        applyStimulus(v_c, 2);
        flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("flush.out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Reset while D is stalled.
        applyStimulus(v_d, 4);
        @(negedge clk);
        checkOutput("prereset.out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkReset("stall_reset");
        @(posedge clk);
        #1 out_ready = 1'b1;

        applyStimulus(v_e, 4);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
